// File: rtl/conways_axil_pkg.sv
// rtl/conways_axil_pkg.sv - register map, response codes and CTRL bit positions
package conways_axil_pkg;

   typedef logic [2:0] word_t;

   localparam word_t REG_CTRL      = 3'd0;
   localparam word_t REG_BOARD_LO  = 3'd1;
   localparam word_t REG_BOARD_HI  = 3'd2;
   localparam word_t REG_GEN_LIMIT = 3'd3;
   localparam word_t REG_STATUS    = 3'd4;
   localparam word_t REG_SCRATCH   = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_RUN_BIT  = 0;
   localparam int CTRL_STEP_BIT = 1;

   // Words 6 and 7 have no backing register.
   function automatic logic word_unmapped(input word_t w);
      return w > REG_SCRATCH;
   endfunction

endpackage

// File: rtl/conways_axil_strb_reg.sv
// rtl/conways_axil_strb_reg.sv - 32-bit register with byte-lane write strobes
module conways_axil_strb_reg #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [3:0]  strb,
   input  logic [31:0] wdata,
   output logic [31:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) q[i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/conways_axil_reg_slave.sv
// rtl/conways_axil_reg_slave.sv - AXI4-Lite register slave for the 8x8 Conway engine
// Optional CONWAYS_AXIL_SLVERR_EN: words 6/7 answer SLVERR instead of OKAY.
module conways_axil_reg_slave #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [15:0] GEN_RESET_VAL      = 16'h0000
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [63:0]                     board_o,
   output logic                            run_o,
   output logic                            step_o,
   output logic [15:0]                     gen_limit_o,
   input  logic                            busy_i,
   input  logic [15:0]                     gen_count_i
);

   import conways_axil_pkg::*;

   localparam int ADDR_LSB = 2;
`ifdef CONWAYS_AXIL_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic        ready_en;
   logic        aw_held, w_held;
   word_t       aw_word_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        run_q, step_q;

   logic        aw_hs, w_hs, ar_hs, commit;
   word_t       wr_word, ar_word;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [1:0]  wr_resp, rd_resp;
   logic [31:0] rd_mux;
   logic [31:0] board_lo_q, board_hi_q, gen_limit_q, scratch_q;

   // Readies stay low through reset and rise on the first cycle after it.
   assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid_q;
   assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid_q;
   assign S_AXI_ARREADY = ready_en & ~rvalid_q;

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // A handshake completing this cycle counts as held, so BVALID follows the later one by a cycle.
   assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
   assign wr_word = aw_held ? aw_word_q : S_AXI_AWADDR[ADDR_LSB +: 3];
   assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
   assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
   assign ar_word = S_AXI_ARADDR[ADDR_LSB +: 3];

   assign wr_resp = (SLVERR_EN && word_unmapped(wr_word)) ? RESP_SLVERR : RESP_OKAY;
   assign rd_resp = (SLVERR_EN && word_unmapped(ar_word)) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ready_en  <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_word_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         run_q     <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held   <= 1'b1;
               aw_word_q <= S_AXI_AWADDR[ADDR_LSB +: 3];
            end
            if (w_hs) begin
               w_held  <= 1'b1;
               wdata_q <= S_AXI_WDATA;
               wstrb_q <= S_AXI_WSTRB;
            end
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
         if (commit && wr_word == REG_CTRL && wr_strb[0]) run_q <= wr_data[CTRL_RUN_BIT];
         step_q <= commit && wr_word == REG_CTRL && wr_strb[0] && wr_data[CTRL_STEP_BIT];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (ar_word)
         REG_CTRL:      rd_mux[CTRL_RUN_BIT] = run_q;
         REG_BOARD_LO:  rd_mux = board_lo_q;
         REG_BOARD_HI:  rd_mux = board_hi_q;
         REG_GEN_LIMIT: rd_mux = gen_limit_q;
         REG_STATUS:    rd_mux = {gen_count_i, 15'b0, busy_i};
         REG_SCRATCH:   rd_mux = scratch_q;
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_mux;
         rresp_q  <= rd_resp;
      end else if (S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   conways_axil_strb_reg #(.RESET_VAL(32'h0)) u_board_lo (
      .clk(ACLK), .rst(ARESET), .we(commit && wr_word == REG_BOARD_LO),
      .strb(wr_strb), .wdata(wr_data), .q(board_lo_q)
   );

   conways_axil_strb_reg #(.RESET_VAL(32'h0)) u_board_hi (
      .clk(ACLK), .rst(ARESET), .we(commit && wr_word == REG_BOARD_HI),
      .strb(wr_strb), .wdata(wr_data), .q(board_hi_q)
   );

   // Upper half never written so it keeps reading zero.
   conways_axil_strb_reg #(.RESET_VAL({16'h0000, GEN_RESET_VAL})) u_gen_limit (
      .clk(ACLK), .rst(ARESET), .we(commit && wr_word == REG_GEN_LIMIT),
      .strb(wr_strb & 4'b0011), .wdata(wr_data), .q(gen_limit_q)
   );

   conways_axil_strb_reg #(.RESET_VAL(32'h0)) u_scratch (
      .clk(ACLK), .rst(ARESET), .we(commit && wr_word == REG_SCRATCH),
      .strb(wr_strb), .wdata(wr_data), .q(scratch_q)
   );

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign board_o      = {board_hi_q, board_lo_q};
   assign run_o        = run_q;
   assign step_o       = step_q;
   assign gen_limit_o  = gen_limit_q[15:0];

   logic unused_inputs;
   assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                            S_AXI_ARADDR[1:0], gen_limit_q[31:16]};

endmodule

// File: tb/tb_conways_axil_reg_slave.sv
// tb/tb_conways_axil_reg_slave.sv - directed self-checking bench for conways_axil_reg_slave
module tb_conways_axil_reg_slave;

`ifdef CONWAYS_AXIL_SLVERR_EN
   localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

   logic tb_ACLK = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   logic        ARESET;
   logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
   logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic        S_AXI_RVALID, S_AXI_RREADY;
   logic [63:0] board_o;
   logic        run_o, step_o, busy_i;
   logic [15:0] gen_limit_o, gen_count_i;

   int tests = 0;
   int fails = 0;
   int step_cnt = 0;
   int step_rise = 0;
   logic step_prev = 1'b0;

   conways_axil_reg_slave dut (
      .ACLK(tb_ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .board_o(board_o), .run_o(run_o), .step_o(step_o), .gen_limit_o(gen_limit_o),
      .busy_i(busy_i), .gen_count_i(gen_count_i)
   );

   always @(negedge tb_ACLK) begin
      if (step_o) step_cnt <= step_cnt + 1;
      if (step_o && !step_prev) step_rise <= step_rise + 1;
      step_prev <= step_o;
   end

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                           input string name);
      int aw_t = -1;
      int w_t = -1;
      int b_t = -1;
      int exp_t;
      S_AXI_BREADY = 1'b1;
      S_AXI_AWADDR = addr;
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      for (int t = 0; t < 20; t++) begin
         if (S_AXI_BVALID) begin
            b_t = t;
            break;
         end
         S_AXI_AWVALID = (aw_t < 0) && (t >= aw_dly);
         S_AXI_WVALID  = (w_t < 0) && (t >= w_dly);
         if (S_AXI_AWVALID && S_AXI_AWREADY) aw_t = t;
         if (S_AXI_WVALID && S_AXI_WREADY) w_t = t;
         @(negedge tb_ACLK);
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      exp_t = ((aw_t > w_t) ? aw_t : w_t) + 1;
      tests++;
      if (b_t < 0 || aw_t < 0 || w_t < 0 || b_t != exp_t) begin
         fails++;
         $display("FAIL %s bvalid_latency: bvalid at cycle %0d, expected %0d", name, b_t, exp_t);
      end
      tests++;
      if (S_AXI_BRESP !== exp_resp) begin
         fails++;
         $display("FAIL %s bresp: got %b expected %b", name, S_AXI_BRESP, exp_resp);
      end
      @(negedge tb_ACLK);
      tests++;
      if (S_AXI_BVALID !== 1'b0) begin
         fails++;
         $display("FAIL %s bvalid_clear: got %b expected 0", name, S_AXI_BVALID);
      end
   endtask

   task automatic do_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string name);
      S_AXI_RREADY  = 1'b1;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      for (int t = 0; t < 20 && !S_AXI_ARREADY; t++) @(negedge tb_ACLK);
      if (!S_AXI_ARREADY) begin
         tests++;
         fails++;
         $display("FAIL %s arready_timeout: got 0 expected 1", name);
      end
      @(negedge tb_ACLK);
      S_AXI_ARVALID = 1'b0;
      tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_data || S_AXI_RRESP !== exp_resp) begin
         fails++;
         $display("FAIL %s read: rvalid=%b rdata=%h rresp=%b expected rvalid=1 rdata=%h rresp=%b",
                  name, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, exp_data, exp_resp);
      end
      @(negedge tb_ACLK);
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
      busy_i = 1'b1; gen_count_i = 16'h1234;
      repeat (3) @(negedge tb_ACLK);
      tests++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, step_o, run_o} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl_flags: got %b expected 0000000",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, step_o, run_o});
      end
      tests++;
      if (board_o !== 64'h0 || gen_limit_o !== 16'h0000) begin
         fails++;
         $display("FAIL reset_regs: board=%h gen_limit=%h expected 0 and 0", board_o, gen_limit_o);
      end
      tests++;
      if (S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00) begin
         fails++;
         $display("FAIL reset_resp: rdata=%h rresp=%b bresp=%b expected zeros", S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP);
      end
      ARESET = 1'b0;
      @(negedge tb_ACLK);
      tests++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         fails++;
         $display("FAIL ready_after_reset: got %b expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      do_read(5'h00, 32'h0, 2'b00, "rd_ctrl");
      do_read(5'h04, 32'h0, 2'b00, "rd_board_lo");
      do_read(5'h08, 32'h0, 2'b00, "rd_board_hi");
      do_read(5'h0C, 32'h0, 2'b00, "rd_gen_limit");
      do_read(5'h10, 32'h1234_0001, 2'b00, "rd_status");
      do_read(5'h14, 32'h0, 2'b00, "rd_scratch");
   endtask

   task automatic test_board_write();
      do_write(5'h04, 32'h0101_FFFF, 4'hF, 0, 2, 2'b00, "wr_board_lo_aw_first");
      do_write(5'h08, 32'hABCD_0001, 4'hF, 2, 0, 2'b00, "wr_board_hi_w_first");
      tests++;
      if (board_o !== 64'hABCD0001_0101FFFF) begin
         fails++;
         $display("FAIL board_o: got %h expected abcd00010101ffff", board_o);
      end
      do_write(5'h0C, 32'hFFFF_1234, 4'hF, 0, 0, 2'b00, "wr_gen_limit");
      tests++;
      if (gen_limit_o !== 16'h1234) begin
         fails++;
         $display("FAIL gen_limit_o: got %h expected 1234", gen_limit_o);
      end
      do_read(5'h0C, 32'h0000_1234, 2'b00, "rd_gen_limit_masked");
      do_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, "wr_status_dropped");
      busy_i = 1'b0; gen_count_i = 16'hBEEF;
      do_read(5'h11, 32'hBEEF_0000, 2'b00, "rd_status_live");
   endtask

   task automatic test_strobe();
      do_write(5'h14, 32'hDEAD_0011, 4'b0101, 1, 1, 2'b00, "wr_scratch_strb");
      do_read(5'h14, 32'h00AD_0011, 2'b00, "rd_scratch_strb");
   endtask

   task automatic test_ctrl_step();
      int c0, r0;
      c0 = step_cnt; r0 = step_rise;
      do_write(5'h00, 32'h0000_0003, 4'hF, 0, 0, 2'b00, "wr_ctrl_run_step");
      @(negedge tb_ACLK);
      tests++;
      if (run_o !== 1'b1 || step_cnt - c0 != 1 || step_rise - r0 != 1) begin
         fails++;
         $display("FAIL step_single: run=%b step_cycles=%0d pulses=%0d expected run=1 1 1",
                  run_o, step_cnt - c0, step_rise - r0);
      end
      do_read(5'h00, 32'h0000_0001, 2'b00, "rd_ctrl_run");
      c0 = step_cnt; r0 = step_rise;
      do_write(5'h00, 32'h0000_0003, 4'b1110, 0, 0, 2'b00, "wr_ctrl_no_lane0");
      do_write(5'h00, 32'h0000_0002, 4'hF, 0, 0, 2'b00, "wr_ctrl_step_a");
      do_write(5'h00, 32'h0000_0002, 4'hF, 0, 0, 2'b00, "wr_ctrl_step_b");
      @(negedge tb_ACLK);
      tests++;
      if (run_o !== 1'b0 || step_cnt - c0 != 2 || step_rise - r0 != 2) begin
         fails++;
         $display("FAIL step_back_to_back: run=%b step_cycles=%0d pulses=%0d expected run=0 2 2",
                  run_o, step_cnt - c0, step_rise - r0);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      S_AXI_AWADDR = 5'h14; S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'hF;
      S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_WDATA = 32'h5555_5555;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) ok = 1'b0;
         @(negedge tb_ACLK);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL b_hold: bvalid=%b awready=%b wready=%b expected 1 0 0 for 5 cycles",
                  S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      tests++;
      if (S_AXI_BVALID !== 1'b0) begin
         fails++;
         $display("FAIL b_release: bvalid=%b expected 0", S_AXI_BVALID);
      end
      @(negedge tb_ACLK);
      do_read(5'h14, 32'h1122_3344, 2'b00, "rd_no_second_commit");

      S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_ARADDR = 5'h04;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hABCD_0001 || S_AXI_ARREADY !== 1'b0) ok = 1'b0;
         @(negedge tb_ACLK);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL r_hold: rvalid=%b rdata=%h arready=%b expected 1 abcd0001 0 for 5 cycles",
                  S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY);
      end
      S_AXI_RREADY = 1'b1; S_AXI_ARVALID = 1'b0;
      @(negedge tb_ACLK);
      tests++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         fails++;
         $display("FAIL r_release: rvalid=%b arready=%b expected 0 1", S_AXI_RVALID, S_AXI_ARREADY);
      end
   endtask

   task automatic test_simul_rw();
      S_AXI_AWADDR = 5'h14; S_AXI_WDATA = 32'h0000_0099; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 5'h14;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h1122_3344 || S_AXI_BVALID !== 1'b1) begin
         fails++;
         $display("FAIL rw_same_reg: rvalid=%b rdata=%h bvalid=%b expected 1 11223344 1",
                  S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
      end
      @(negedge tb_ACLK);
      do_read(5'h14, 32'h0000_0099, 2'b00, "rd_after_rw");
   endtask

   task automatic test_unmapped_and_reset();
      bit ok;
      do_read(5'h18, 32'h0, EXP_UNMAPPED, "rd_word6");
      do_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, EXP_UNMAPPED, "wr_word7");
      do_read(5'h14, 32'h0000_0099, 2'b00, "rd_scratch_after_unmapped");

      S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 5'h18; S_AXI_ARVALID = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_ARVALID = 1'b0;
      ARESET = 1'b1;
      @(negedge tb_ACLK);
      tests++;
      if (S_AXI_RVALID !== 1'b0 || board_o !== 64'h0) begin
         fails++;
         $display("FAIL reset_mid_read: rvalid=%b board=%h expected 0 0", S_AXI_RVALID, board_o);
      end
      ARESET = 1'b0;
      @(negedge tb_ACLK);
      S_AXI_AWADDR = 5'h14; S_AXI_AWVALID = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_AWVALID = 1'b0;
      ARESET = 1'b1;
      @(negedge tb_ACLK);
      ARESET = 1'b0;
      @(negedge tb_ACLK);
      S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      @(negedge tb_ACLK);
      S_AXI_WVALID = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) ok = 1'b0;
         @(negedge tb_ACLK);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL reset_discards_aw: bvalid=%b rvalid=%b expected 0 0", S_AXI_BVALID, S_AXI_RVALID);
      end
      do_read(5'h14, 32'h0, 2'b00, "rd_scratch_after_reset");
   endtask

   initial begin
      test_reset();
      test_board_write();
      test_strobe();
      test_ctrl_step();
      test_backpressure();
      test_simul_rw();
      test_unmapped_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
